// File: rtl/gb_int_ctrl_if.sv
// CPU-side bus and interrupt handshake bundle for gb_int_ctrl.
// master = CPU / bench side, slave = interrupt controller side.
interface gb_int_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  rd_data;
  logic        rd_sel;
  logic        int_n;
  logic        int_ack;
  logic [15:0] int_vec;
  logic        int_vec_valid;

  modport master (
    output addr, wr_data, rd_n, wr_n, int_ack,
    input  rd_data, rd_sel, int_n, int_vec, int_vec_valid
  );

  modport slave (
    input  addr, wr_data, rd_n, wr_n, int_ack,
    output rd_data, rd_sel, int_n, int_vec, int_vec_valid
  );
endinterface

// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: IF (0xFF0F) / IE (0xFFFF), request edge capture, CPU int handshake.
// Define GB_INT_SYNC_EN to pass irq_src through a two-flop synchronizer before edge detection.
module gb_int_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   irq_src,
  gb_int_ctrl_if.slave bus
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [4:0]  irq_s;
  logic [4:0]  irq_prev_q;
  logic        wr_hi_q;
  logic        ack_lo_q;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] vec_q, vec_d;
  logic        valid_q, valid_d;
  logic [7:0]  rd_data_q;
  logic        rd_sel_q;

  logic [4:0]  irq_rise;
  logic        wr_stb;
  logic        ack_rise;
  logic [4:0]  pending;
  logic [4:0]  ack_sel;
  logic [15:0] ack_vec;
  logic [4:0]  clr;
  logic        found;
  logic        rd_hit;
  logic [7:0]  rd_val;

`ifdef GB_INT_SYNC_EN
  logic [4:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_src;
`endif

  // wr_hi_q / ack_lo_q record "was inactive last cycle"; clearing them in reset
  // means a strobe already asserted at reset release never counts as an edge.
  assign irq_rise = irq_s & ~irq_prev_q;
  assign wr_stb   = wr_hi_q & ~bus.wr_n;
  assign ack_rise = bus.int_ack & ack_lo_q;
  assign pending  = ie_q[4:0] & if_q;

  always_comb begin
    found   = 1'b0;
    ack_sel = '0;
    ack_vec = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (pending[i] && !found) begin
        found      = 1'b1;
        ack_sel[i] = 1'b1;
        ack_vec    = 16'h0040 + 16'(i * 8);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    valid_d = valid_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (ack_rise) begin
          state_d = ST_ACK;
          vec_d   = '0;
          valid_d = 1'b1;
        end else if (|pending) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_rise) begin
          state_d = ST_ACK;
          vec_d   = ack_vec;
          valid_d = 1'b1;
          clr     = ack_sel;
        end else if (!(|pending)) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!bus.int_ack) state_d = (|pending) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ordering encodes precedence: CPU write, then ack clear, then new request edges.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (wr_stb && bus.addr == ADDR_IF) if_d = bus.wr_data[4:0];
    if (wr_stb && bus.addr == ADDR_IE) ie_d = bus.wr_data;
    if_d = (if_d & ~clr) | irq_rise;
  end

  assign rd_hit = !bus.rd_n && (bus.addr == ADDR_IF || bus.addr == ADDR_IE);
  assign rd_val = (bus.addr == ADDR_IF) ? {3'b111, if_q} : ie_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      wr_hi_q    <= 1'b0;
      ack_lo_q   <= 1'b0;
      if_q       <= '0;
      ie_q       <= '0;
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      valid_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_sel_q   <= 1'b0;
    end else begin
      irq_prev_q <= irq_s;
      wr_hi_q    <= bus.wr_n;
      ack_lo_q   <= ~bus.int_ack;
      if_q       <= if_d;
      ie_q       <= ie_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      valid_q    <= valid_d;
      rd_sel_q   <= rd_hit;
      rd_data_q  <= rd_hit ? rd_val : '0;
    end
  end

  assign bus.int_n         = (state_q != ST_REQ);
  assign bus.int_vec       = vec_q;
  assign bus.int_vec_valid = valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_sel        = rd_sel_q;

endmodule
